jt6295_accmix: RTL

//  Parametrised voice mixer/decimator for the ADPCM sound path. Sums CH time-multiplexed

---
 rtl/jt6295_accmix_if.sv | 22 ++
 rtl/jt6295_accmix.sv | 129 ++++++++++++
 2 files changed

// File: rtl/jt6295_accmix_if.sv
// Voice-slot bus between the ADPCM voice decoder (master) and the accumulating mixer (slave).
interface jt6295_accmix_if #(
    parameter int unsigned IW = 12,
    parameter int unsigned OW = 14
);
    logic                 cen;
    logic                 cen_ch;
    logic signed [IW-1:0] sound_in;
    logic signed [OW-1:0] sound_out;
    logic                 sample;
    logic                 overrun;

    modport master (
        output cen, cen_ch, sound_in,
        input  sound_out, sample, overrun
    );

    modport slave (
        input  cen, cen_ch, sound_in,
        output sound_out, sample, overrun
    );
endinterface

// File: rtl/jt6295_accmix.sv
// Voice mixer/decimator: sums CH voice slots per frame, saturates to OW bits.
// Define JT6295_INTERP_EN for per-slot linear interpolation instead of a frame-long hold.
module jt6295_accmix #(
    parameter int unsigned CH = 4,
    parameter int unsigned IW = 12,
    parameter int unsigned OW = 14
) (
    input logic            clk,
    input logic            rst,
    jt6295_accmix_if.slave bus
);
    localparam int unsigned LW = $clog2(CH);
    localparam int unsigned AW = IW + LW;
    localparam int unsigned SW = AW + 1;
    localparam int unsigned CW = (SW > OW ? SW : OW) + 1;
    localparam logic [LW:0] SLOTS = CH[LW:0];
    localparam logic signed [CW-1:0] OMAX = {{(CW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [CW-1:0] OMIN = {{(CW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    // Widen first so the same compare works whether AW is above or below OW.
    function automatic logic signed [OW-1:0] sat(input logic signed [SW-1:0] x);
        logic signed [CW-1:0] xe;
        xe = {{(CW-SW){x[SW-1]}}, x};
        if (xe > OMAX) return OMAX[OW-1:0];
        if (xe < OMIN) return OMIN[OW-1:0];
        return xe[OW-1:0];
    endfunction

    logic signed [AW-1:0] smp;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [AW-1:0] cur_q, cur_d;
    logic [LW:0]          slot_q, slot_d;
    logic signed [OW-1:0] out_q, out_d;
    logic                 sample_q, sample_d;
    logic                 overrun_q, overrun_d;

    always_comb begin
        smp = {{LW{bus.sound_in[IW-1]}}, bus.sound_in};
    end

    // A sample on a cen cycle opens the new frame; cur takes the finished sum.
    always_comb begin
        acc_d     = acc_q;
        slot_d    = slot_q;
        cur_d     = cur_q;
        overrun_d = 1'b0;
        if (bus.cen) begin
            cur_d  = acc_q;
            acc_d  = bus.cen_ch ? smp : '0;
            slot_d = bus.cen_ch ? (LW+1)'(1) : '0;
        end else if (bus.cen_ch) begin
            if (slot_q < SLOTS) begin
                acc_d  = acc_q + smp;
                slot_d = slot_q + (LW+1)'(1);
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

`ifdef JT6295_INTERP_EN
    localparam int unsigned PW = SW + LW + 1;
    localparam logic [LW-1:0] STEP_MAX = LW'(CH - 1);

    logic signed [AW-1:0] prev_q, prev_d;
    logic [LW-1:0]        step_q, step_d;
    logic signed [SW-1:0] diff, shf, yv;
    logic signed [PW-1:0] dx, kx, prod;

    // Interpolate from the post-update frame pair so slot 0 of a frame yields exactly prev.
    always_comb begin
        prev_d = bus.cen ? cur_q : prev_q;
        if (bus.cen) begin
            step_d = '0;
        end else if (bus.cen_ch && step_q != STEP_MAX) begin
            step_d = step_q + LW'(1);
        end else begin
            step_d = step_q;
        end
        diff     = {cur_d[AW-1], cur_d} - {prev_d[AW-1], prev_d};
        dx       = {{(LW+1){diff[SW-1]}}, diff};
        kx       = {{(SW+1){1'b0}}, step_d};
        prod     = dx * kx;
        shf      = SW'(prod >>> LW);
        yv       = {prev_d[AW-1], prev_d} + shf;
        out_d    = bus.cen_ch ? sat(yv) : out_q;
        sample_d = bus.cen_ch;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            step_q <= '0;
        end else begin
            prev_q <= prev_d;
            step_q <= step_d;
        end
    end
`else
    always_comb begin
        out_d    = bus.cen ? sat({cur_d[AW-1], cur_d}) : out_q;
        sample_d = bus.cen;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            cur_q     <= '0;
            slot_q    <= '0;
            out_q     <= '0;
            sample_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cur_q     <= cur_d;
            slot_q    <= slot_d;
            out_q     <= out_d;
            sample_q  <= sample_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        bus.sound_out = out_q;
        bus.sample    = sample_q;
        bus.overrun   = overrun_q;
    end
endmodule
